arbitro_vc: RTL
===============

Name: arbitro_vc

Overview:
- Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the four destination FIFOs (D0-D3) of the transaction layer.
- Pops one word per cycle from the chosen VC and pushes it, one cycle later, to the destination FIFO selected by the word's two MSBs.
- Backpressure comes from the destination almost-full flags.
- Runs only while the main transaction FSM reports ACTIVE, via the enable input.

Parameters:
DATA_WIDTH, 6, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination index 0-3
WEIGHT, 4, maximum consecutive VC0 grants before VC1 is preferred (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state and outputs immediately
enable  in  1  1 = scheduling allowed (driven from FSM active indication)
vc0_empty  in  1  VC0 FIFO empty
vc1_empty  in  1  VC1 FIFO empty
vc0_data  in  DATA_WIDTH  VC0 head word (show-ahead, valid while not empty)
vc1_data  in  DATA_WIDTH  VC1 head word
d_almost_full  in  4  almost-full flag per destination FIFO, bit i = Di
pop_vc0  out  1  combinational pop strobe to VC0
pop_vc1  out  1  combinational pop strobe to VC1
push_d  out  4  registered one-hot push strobe to Di
data_out  out  DATA_WIDTH  registered word for the destination FIFOs
state  out  2  registered scheduler state: 0 IDLE, 1 RUN, 2 WAIT, 3 BLOCKED
pkt_count  out  8  registered count of words pushed

Behaviour:
- Reset (reset=0, async):
  - push_d=0, data_out=0, state=IDLE, pkt_count=0, credit counter=0.
  - pop_vc0/pop_vc1 are forced 0 while reset=0.
- Destination of a head word: dest(x) = vcx_data[DATA_WIDTH-1:DATA_WIDTH-2].
- Eligibility: VCx is eligible iff enable=1, vcx_empty=0 and d_almost_full[dest(x)]=0.
- Grant rules (combinational, evaluated in the same cycle; at most one pop per cycle):
  1. credit<WEIGHT and VC0 eligible -> pop_vc0=1; credit <= credit+1.
  2. Else if VC1 eligible -> pop_vc1=1; credit <= 0.
  3. Else if VC0 eligible (credit==WEIGHT) -> pop_vc0=1; credit holds at WEIGHT.
  4. Else no pop; credit holds.
- Work-conserving: a blocked preferred VC never stalls an eligible other VC.
- Push latency is exactly 1 cycle. On the edge after a pop:
  - data_out <= popped word.
  - push_d <= one-hot(dest) for exactly one cycle.
  - pkt_count <= pkt_count+1, wrapping 255->0.
- Without a pop, push_d <= 0 and data_out holds its last value.
- One word may be in flight per cycle after almost-full is seen, so destination FIFOs must set their almost-full threshold with at least 1 entry of slack. The block does not check full.
- state register, updated every edge:
  - IDLE: enable=0.
  - RUN: a pop occurred this cycle.
  - WAIT: enable=1, both VCs empty.
  - BLOCKED: enable=1, at least one VC non-empty, but no pop.
- enable falling:
  - Pops stop in that same cycle.
  - A word popped in the previous cycle is still pushed.
  - credit is retained.
- Both VCs eligible with credit<WEIGHT: VC0 wins. With credit==WEIGHT: VC1 wins.
- Same destination on both heads and that destination almost full: BLOCKED, no pop from either VC.
- Reset asserted mid-transfer: the in-flight popped word is discarded (push_d cleared asynchronously). This loss is accepted; the FSM reinitialises the FIFOs on reset.
- Enable or almost-full toggling every cycle: grants follow the current-cycle inputs only; there is no hidden pending state beyond credit.

Test Plan:
- Reset: hold reset=0 with both VCs non-empty and enable=1 -> pop_vc0=pop_vc1=0, push_d=0, state=0, pkt_count=0. Release reset -> first pop on VC0 in the same cycle.
- Weighting: WEIGHT=4, both VCs full, all almost-full=0 -> pop sequence VC0,VC0,VC0,VC0,VC1, repeating. pkt_count=10 after 10 pops. Each push_d one cycle after its pop.
- Routing: VC1 only, heads 6'b00_0001, 6'b01_0010, 6'b10_0011, 6'b11_0100 -> push_d = 0001, 0010, 0100, 1000 on consecutive cycles, with data_out matching each word.
- Backpressure bypass: VC0 head dest=2 with d_almost_full=4'b0100, VC1 head dest=1 -> pop_vc1=1 each cycle, state=RUN. Then VC1 empties -> state=BLOCKED with no pop. Clear d_almost_full[2] -> VC0 resumes next cycle.
- Enable/idle: enable 1->0 in the cycle after a pop -> that word is still pushed, no new pop, state=IDLE. enable=1 with both empty -> state=WAIT.
- Wrap: preload 255 pushes, push one more -> pkt_count=0. Assert reset mid-pop -> push_d=0 immediately and pkt_count=0.

Source files
------------

// File: rtl/arbitro_vc.sv
// Weighted round-robin scheduler from two virtual-channel FIFOs to four destination FIFOs.
// Pops are combinational; the popped word is pushed to its destination on the following edge.
module arbitro_vc #(
    parameter int DATA_WIDTH = 6,
    parameter int WEIGHT     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic [3:0]            d_almost_full,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic [3:0]            push_d,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            state,
    output logic [7:0]            pkt_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT    = 2'd2,
        BLOCKED = 2'd3
    } state_t;

    localparam logic [3:0] WEIGHT_C = 4'(WEIGHT);

    state_t                  state_p1, state_nxt;
    logic [3:0]              credit_p1, credit_nxt;
    logic [1:0]              dest0, dest1, dest_sel;
    logic                    elig0, elig1;
    logic                    grant0, grant1, popped;
    logic [DATA_WIDTH-1:0]   word_sel;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Stage p0: eligibility and grant, evaluated within the current cycle
    assign dest0 = vc0_data[DATA_WIDTH-1 -: 2];
    assign dest1 = vc1_data[DATA_WIDTH-1 -: 2];
    assign elig0 = enable & ~vc0_empty & ~d_almost_full[dest0];
    assign elig1 = enable & ~vc1_empty & ~d_almost_full[dest1];

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        credit_nxt = credit_p1;
        if (reset) begin
            if (credit_p1 < WEIGHT_C && elig0) begin
                grant0     = 1'b1;
                credit_nxt = credit_p1 + 4'd1;
            end else if (elig1) begin
                grant1     = 1'b1;
                credit_nxt = 4'd0;
            end else if (elig0) begin
                grant0     = 1'b1;
            end
        end
    end

    assign pop_vc0  = grant0;
    assign pop_vc1  = grant1;
    assign popped   = grant0 | grant1;
    assign word_sel = grant1 ? vc1_data : vc0_data;
    assign dest_sel = word_sel[DATA_WIDTH-1 -: 2];

    always_comb begin
        state_nxt = IDLE;
        if (!enable)
            state_nxt = IDLE;
        else if (popped)
            state_nxt = RUN;
        else if (vc0_empty && vc1_empty)
            state_nxt = WAIT;
        else
            state_nxt = BLOCKED;
    end

    // Stage p1: push of the popped word, counters and state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1  <= IDLE;
            credit_p1 <= 4'd0;
            push_d    <= 4'd0;
            data_out  <= '0;
            pkt_count <= 8'd0;
        end else begin
            state_p1  <= state_nxt;
            credit_p1 <= credit_nxt;
            push_d    <= popped ? onehot(dest_sel) : 4'd0;
            if (popped) begin
                data_out  <= word_sel;
                pkt_count <= pkt_count + 8'd1;
            end
        end
    end

    assign state = state_p1;

endmodule
